forward_hazard_unit: RTL and testbench
======================================

Name: forward_hazard_unit

Overview:
- Producer side of the Execute-stage forwarding interface: generates the ForwardA/ForwardB mux selects the Execute stage consumes, plus the load-use stall request to the fetch/decode pipeline registers.
- Keeps its own shadow pipeline (EX, MEM, WB slots) of register-use and destination information, fed from decode. Its outputs depend only on its own registered state and the current decode fields.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- REG_AW, 5, register-specifier width.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- Clk  in  1  pipeline clock
- Rst  in  1  synchronous, active-low reset
- ID_Rs  in  REG_AW  decode instruction [25:21]
- ID_Rt  in  REG_AW  decode instruction [20:16]
- ID_Rd  in  REG_AW  decode instruction [15:11]
- ID_UsesRs  in  1  decode instruction reads rs
- ID_UsesRt  in  1  decode instruction reads rt
- ID_RegWrite  in  1  decode instruction writes a GPR
- ID_MemRead  in  1  decode instruction is a load
- ID_RegDst  in  1  1 = destination is rd, 0 = destination is rt
- ID_ALUSrc  in  1  1 = ALU B operand is the immediate
- Flush  in  1  squash the decode instruction (taken branch/jump)
- ForwardA  out  2  Execute A-operand select
- ForwardB  out  2  Execute B-operand select
- Stall  out  1  hold PC and IF/ID, bubble ID/EX
- StallCount  out  CNT_W  number of cycles with Stall asserted

Behaviour:
- Select encoding (shared with Execute):
  - 2'b00 = register-file data
  - 2'b01 = WB-stage data
  - 2'b10 = MEM-stage data
  - 2'b11 is never driven.
- Slot contents:
  - EX slot = {rs, rt, usesRs, usesRt, aluSrc, dst, regWrite, memRead}.
  - MEM and WB slots = {dst, regWrite}.
  - A bubble is any slot with regWrite=0, memRead=0, usesRs=0, usesRt=0.
- Reset: when Rst==0 at posedge, all slots become bubbles and StallCount is set to 0. Outputs after reset: ForwardA=00, ForwardB=00, Stall=0, StallCount=0. Reset overrides Stall and Flush in the same cycle.
- Each posedge, when Rst==1:
  - WB <= MEM
  - MEM <= EX
  - EX <= bubble if (Stall | Flush), else the decode fields
  - EX.dst = ID_RegDst ? ID_Rd : ID_Rt
- ForwardA is combinational from registered slots only:
  - 10 if EX.usesRs & MEM.regWrite & MEM.dst!=0 & MEM.dst==EX.rs
  - else 01 if the same condition holds for WB
  - else 00
- ForwardB uses the same rules on EX.rt/EX.usesRt, but is forced to 00 whenever EX.aluSrc==1. This is required because the forward mux sits after the ALUSrc mux, and forwarding there would overwrite the immediate.
- Priority: MEM beats WB when both match (the youngest producer wins).
- Register 0 is never forwarded, whatever the regWrite value.
- Stall (combinational) is asserted when all of the following hold:
  - EX.memRead & EX.regWrite & EX.dst!=0
  - (ID_UsesRs & ID_Rs==EX.dst) | (ID_UsesRt & ID_Rt==EX.dst)
- Stall behaviour:
  - Stall lasts exactly 1 cycle per load-use pair, because the bubble then occupies EX.
  - The next cycle the load is in MEM, which is too early to forward loaded data. The consumer therefore re-enters EX once the load reaches WB and receives select 01.
- Flush with Stall in the same cycle: EX is loaded with a bubble (one bubble, not two), and StallCount still increments.
- StallCount increments on each posedge with Stall==1 and Rst==1, and saturates at all-ones.
- Latency: selects are valid in the same cycle the consumer occupies EX; Stall is valid in the same cycle the consumer occupies ID.

Decomposition:
- Shared pipeline package holds:
  - the forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_AW
  - the slot struct typedefs
- One natural sub-module, fwd_select: the combinational compare for one operand (inputs src, uses, MEM/WB dst+regWrite, force-zero). It is instantiated twice, for A and for B.

Test Plan:
- add $3,$1,$2 then add $4,$3,$5 -> in the second instruction's EX cycle, ForwardA=10, ForwardB=00.
- add $3,… ; nop ; sub $6,$3,$3 -> in the sub's EX cycle, ForwardA=01 and ForwardB=01.
- lw $8,0($9) then add $10,$8,$1 -> Stall=1 for exactly one cycle, StallCount goes 0->1, and in the add's EX cycle ForwardA=01.
- addi $0,$1,5 followed by add $2,$0,$0 -> ForwardA=ForwardB=00 and Stall=0, both for the $0 destination; then addi $7,$3,4 after a writer of $3 -> ForwardA=10, and ForwardB stays 00 while aluSrc=1 even when the rt field matches.
- Writers of $5 in both MEM and WB, then a reader of $5 -> ForwardA=10 (MEM priority).
- Rst=0 asserted mid-stall with Flush=1 -> the next cycle has all selects 00, Stall=0, StallCount=0; a load followed by Flush=1 -> the squashed consumer produces no forwarding.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// Shared pipeline definitions for the Execute-stage forwarding unit:
// forward-select encodings, register-specifier width and shadow-slot types.
package forward_hazard_unit_pkg;

    localparam int REG_AW = 5;

    // Select encoding shared with the Execute-stage operand muxes.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX shadow slot: everything needed to compute selects and load-use stalls.
    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
        logic              alu_src;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
    } ex_slot_t;

    // MEM and WB shadow slots only need to identify the producer.
    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } wr_slot_t;

    localparam ex_slot_t EX_BUBBLE = '0;
    localparam wr_slot_t WR_BUBBLE = '0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Decode-to-hazard-unit bundle. There is no valid/ready handshake here: the
// decode side presents the instruction in ID every cycle (a nop simply has all
// use/write flags low), and the hazard unit answers combinationally in the
// same cycle with Stall for that ID instruction and selects for the EX one.
interface forward_hazard_unit_if
    import forward_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic [REG_AW-1:0] ID_Rd;
    logic              ID_UsesRs;
    logic              ID_UsesRt;
    logic              ID_RegWrite;
    logic              ID_MemRead;
    logic              ID_RegDst;
    logic              ID_ALUSrc;
    logic              Flush;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              Stall;
    logic [CNT_W-1:0]  StallCount;

    // Decode / pipeline-control side.
    modport master (
        output ID_Rs, ID_Rt, ID_Rd, ID_UsesRs, ID_UsesRt, ID_RegWrite,
               ID_MemRead, ID_RegDst, ID_ALUSrc, Flush,
        input  ForwardA, ForwardB, Stall, StallCount
    );

    // Hazard unit side.
    modport slave (
        input  ID_Rs, ID_Rt, ID_Rd, ID_UsesRs, ID_UsesRt, ID_RegWrite,
               ID_MemRead, ID_RegDst, ID_ALUSrc, Flush,
        output ForwardA, ForwardB, Stall, StallCount
    );

endinterface

// File: rtl/forward_hazard_unit_fwd_select.sv
// Forward-select compare for one Execute operand. The MEM producer is younger
// than the WB producer, so it wins when both match. $0 is never forwarded.
module fwd_select
    import forward_hazard_unit_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_reg_write,
    input  logic              force_zero,
    output logic [1:0]        sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = uses && mem_reg_write && (mem_dst != '0) && (mem_dst == src);
    assign wb_hit  = uses && wb_reg_write && (wb_dst != '0) && (wb_dst == src);

    // Priority pick: forced register path, then MEM, then WB, else register file.
    always_comb begin
        sel = FWD_REG;
        if (force_zero) begin
            sel = FWD_REG;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Execute-stage forwarding and load-use stall unit. Tracks a shadow copy of
// the EX/MEM/WB register-use information and derives operand selects and the
// stall request from it plus the current decode fields.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    forward_hazard_unit_if.slave bus
);

    ex_slot_t         ex_slot;
    wr_slot_t         mem_slot;
    wr_slot_t         wb_slot;
    ex_slot_t         id_slot;
    logic             stall;
    logic             load_use_rs;
    logic             load_use_rt;
    logic [CNT_W-1:0] stall_count;

    // Decode fields packed into an EX slot; destination picked by RegDst.
    always_comb begin
        id_slot           = EX_BUBBLE;
        id_slot.rs        = bus.ID_Rs;
        id_slot.rt        = bus.ID_Rt;
        id_slot.uses_rs   = bus.ID_UsesRs;
        id_slot.uses_rt   = bus.ID_UsesRt;
        id_slot.alu_src   = bus.ID_ALUSrc;
        id_slot.dst       = bus.ID_RegDst ? bus.ID_Rd : bus.ID_Rt;
        id_slot.reg_write = bus.ID_RegWrite;
        id_slot.mem_read  = bus.ID_MemRead;
    end

    // A load in EX cannot forward to the instruction in ID in time.
    assign load_use_rs = bus.ID_UsesRs && (bus.ID_Rs == ex_slot.dst);
    assign load_use_rt = bus.ID_UsesRt && (bus.ID_Rt == ex_slot.dst);
    assign stall = ex_slot.mem_read && ex_slot.reg_write && (ex_slot.dst != '0)
                   && (load_use_rs || load_use_rt);

    // Shadow pipeline advance; a stall or flush injects a single bubble into EX.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ex_slot  <= EX_BUBBLE;
            mem_slot <= WR_BUBBLE;
            wb_slot  <= WR_BUBBLE;
        end else begin
            wb_slot            <= mem_slot;
            mem_slot.dst       <= ex_slot.dst;
            mem_slot.reg_write <= ex_slot.reg_write;
            ex_slot            <= (stall || bus.Flush) ? EX_BUBBLE : id_slot;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    fwd_select u_fwd_a (
        .src           (ex_slot.rs),
        .uses          (ex_slot.uses_rs),
        .mem_dst       (mem_slot.dst),
        .mem_reg_write (mem_slot.reg_write),
        .wb_dst        (wb_slot.dst),
        .wb_reg_write  (wb_slot.reg_write),
        .force_zero    (1'b0),
        .sel           (bus.ForwardA)
    );

    // B forwarding sits after the ALUSrc mux, so an immediate operand must win.
    fwd_select u_fwd_b (
        .src           (ex_slot.rt),
        .uses          (ex_slot.uses_rt),
        .mem_dst       (mem_slot.dst),
        .mem_reg_write (mem_slot.reg_write),
        .wb_dst        (wb_slot.dst),
        .wb_reg_write  (wb_slot.reg_write),
        .force_zero    (ex_slot.alu_src),
        .sel           (bus.ForwardB)
    );

    assign bus.Stall      = stall;
    assign bus.StallCount = stall_count;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: short instruction sequences with
// hand-computed selects, stall and stall-count values.
module tb_forward_hazard_unit;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;

    forward_hazard_unit_if #(.CNT_W(32)) bus ();

    forward_hazard_unit #(.CNT_W(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Clock: 10 time-unit period.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one cycle and land just after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one decode instruction; outputs are allowed to settle.
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic uses_rs, input logic uses_rt, input logic reg_write,
                          input logic mem_read, input logic reg_dst, input logic alu_src);
        bus.ID_Rs       = rs;
        bus.ID_Rt       = rt;
        bus.ID_Rd       = rd;
        bus.ID_UsesRs   = uses_rs;
        bus.ID_UsesRt   = uses_rt;
        bus.ID_RegWrite = reg_write;
        bus.ID_MemRead  = mem_read;
        bus.ID_RegDst   = reg_dst;
        bus.ID_ALUSrc   = alu_src;
        #1;
    endtask

    // R-type rd <- rs op rt.
    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    // I-type ALU rt <- rs op imm.
    task automatic itype(input logic [4:0] rt, input logic [4:0] rs);
        set_id(rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // Load rt <- mem[rs + imm].
    task automatic load(input logic [4:0] rt, input logic [4:0] rs);
        set_id(rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic nop();
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sel(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        check({tag, "_fa"}, {30'd0, bus.ForwardA}, {30'd0, fa});
        check({tag, "_fb"}, {30'd0, bus.ForwardB}, {30'd0, fb});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Rst       = 1'b0;
        bus.Flush = 1'b0;
        nop();

        // Reset state.
        tick();
        tick();
        check_sel("reset", 2'b00, 2'b00);
        check("reset_stall", {31'd0, bus.Stall}, 32'd0);
        check("reset_cnt", bus.StallCount, 32'd0);
        Rst = 1'b1;

        // add $3,$1,$2 ; add $4,$3,$5 -> EX/MEM forward on A.
        rtype(5'd3, 5'd1, 5'd2);
        tick();
        rtype(5'd4, 5'd3, 5'd5);
        check("alu_alu_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        check_sel("mem_fwd", 2'b10, 2'b00);

        // add $3 ; nop ; sub $6,$3,$3 -> WB forward on both operands.
        rtype(5'd3, 5'd1, 5'd2);
        tick();
        nop();
        tick();
        rtype(5'd6, 5'd3, 5'd3);
        tick();
        check_sel("wb_fwd", 2'b01, 2'b01);

        // lw $8,0($9) ; add $10,$8,$1 -> one stall cycle, then WB forward.
        load(5'd8, 5'd9);
        tick();
        rtype(5'd10, 5'd8, 5'd1);
        check("lu_stall_on", {31'd0, bus.Stall}, 32'd1);
        check("lu_cnt_before", bus.StallCount, 32'd0);
        tick();
        check("lu_stall_off", {31'd0, bus.Stall}, 32'd0);
        check("lu_cnt_after", bus.StallCount, 32'd1);
        check_sel("lu_bubble", 2'b00, 2'b00);
        tick();
        check_sel("lu_fwd", 2'b01, 2'b00);
        check("lu_cnt_hold", bus.StallCount, 32'd1);

        // addi $0,$1,5 ; add $2,$0,$0 -> $0 never forwarded.
        itype(5'd0, 5'd1);
        tick();
        rtype(5'd2, 5'd0, 5'd0);
        check("r0_stall", {31'd0, bus.Stall}, 32'd0);
        tick();
        check_sel("r0_fwd", 2'b00, 2'b00);

        // lw $0 ; add $2,$0,$0 -> no load-use stall on $0.
        load(5'd0, 5'd9);
        tick();
        rtype(5'd2, 5'd0, 5'd0);
        check("r0_load_stall", {31'd0, bus.Stall}, 32'd0);
        tick();

        // add $7 ; add $3 ; addi $7,$3,4 ; store-like rs=$3 rt=$7 with aluSrc.
        rtype(5'd7, 5'd1, 5'd2);
        tick();
        rtype(5'd3, 5'd1, 5'd2);
        tick();
        itype(5'd7, 5'd3);
        tick();
        check_sel("addi_fwd", 2'b10, 2'b00);
        set_id(5'd3, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_sel("alusrc_force", 2'b01, 2'b00);

        // Writers of $5 in MEM and WB, then a reader -> MEM wins.
        rtype(5'd5, 5'd1, 5'd2);
        tick();
        rtype(5'd5, 5'd1, 5'd2);
        tick();
        rtype(5'd9, 5'd5, 5'd0);
        tick();
        check_sel("mem_priority", 2'b10, 2'b00);

        // Flush without stall: squashed writer of $3 is not forwarded.
        rtype(5'd3, 5'd1, 5'd2);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        rtype(5'd11, 5'd3, 5'd3);
        tick();
        check_sel("flush_writer", 2'b00, 2'b00);

        // Reset mid-stall with Flush -> everything back to idle.
        load(5'd8, 5'd9);
        tick();
        rtype(5'd10, 5'd8, 5'd1);
        check("rst_pre_stall", {31'd0, bus.Stall}, 32'd1);
        Rst       = 1'b0;
        bus.Flush = 1'b1;
        tick();
        check_sel("rst_mid", 2'b00, 2'b00);
        check("rst_mid_stall", {31'd0, bus.Stall}, 32'd0);
        check("rst_mid_cnt", bus.StallCount, 32'd0);
        Rst       = 1'b1;
        bus.Flush = 1'b0;

        // Load then flushed consumer: one bubble, count still increments.
        load(5'd8, 5'd9);
        tick();
        rtype(5'd10, 5'd8, 5'd8);
        bus.Flush = 1'b1;
        check("flush_stall", {31'd0, bus.Stall}, 32'd1);
        tick();
        bus.Flush = 1'b0;
        nop();
        check("flush_cnt", bus.StallCount, 32'd1);
        check("flush_stall_off", {31'd0, bus.Stall}, 32'd0);
        tick();
        check_sel("flush_consumer", 2'b00, 2'b00);
        tick();
        check_sel("flush_drain", 2'b00, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
